cdb_arbiter: RTL and testbench

Round-robin arbiter sharing a single Common Data Bus among `N_FU` functional units (ALU, mult, load, branch FUs). Each cycle it selects one FU whose registered output packet is `done`, returns `ack` to that FU so the FU may clear or reload its output register, and broadcasts the selected result on a registered CDB packet consumed by the ROB and reservation stations. It sits between the FU output registers and the ROB/RS wakeup logic.

---
 rtl/cdb_arbiter_pkg.sv | 42 ++++
 rtl/cdb_arbiter_rr_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: FU output packets, CDB broadcast packet and the default FU count.
// Optional feature macro used by the arbiter: CDB_RR_EN (round-robin; otherwise fixed priority).
package cdb_arbiter_pkg;

    localparam int N_FU_DEF  = 4;
    localparam int ROB_TAG_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 done;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      v;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_loc;
        logic                 mispredicted;
        logic [XLEN-1:0]      origin_PC;
    } FU_OUT_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      v;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_loc;
        logic                 mispredicted;
        logic [XLEN-1:0]      origin_PC;
    } CDB_PACKET;

    // Payload is copied field by field; valid is forced high for a real grant.
    function automatic CDB_PACKET fu_to_cdb(input FU_OUT_PACKET f);
        CDB_PACKET c;
        c.valid        = 1'b1;
        c.rob_tag      = f.rob_tag;
        c.v            = f.v;
        c.take_branch  = f.take_branch;
        c.branch_loc   = f.branch_loc;
        c.mispredicted = f.mispredicted;
        c.origin_PC    = f.origin_PC;
        return c;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Masked priority encoder: first set request at or above ptr, wrapping modulo N.
// With ptr tied to 0 it degenerates to a plain lowest-index-wins encoder.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one done FU per cycle and registers its result as the CDB broadcast.
// `define CDB_RR_EN for round-robin selection; without it the lowest-index FU always wins.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU  = N_FU_DEF,
    parameter int PTR_W = $clog2(N_FU)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             cdb_stall,
    input  FU_OUT_PACKET     fu_out_packet [N_FU],
    output logic [N_FU-1:0]  ack,
    output CDB_PACKET        cdb_packet,
    output logic [PTR_W-1:0] grant_idx
);

    logic [N_FU-1:0]  req;
    logic [N_FU-1:0]  pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [PTR_W-1:0] search_base;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_FU; i++) begin
            req[i] = fu_out_packet[i].done;
        end
    end

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!squash && !cdb_stall && pick_any) begin
            rr_ptr <= (int'(pick_idx) == N_FU - 1) ? '0 : pick_idx + PTR_W'(1);
        end
    end

    assign search_base = rr_ptr;
`else
    assign search_base = '0;
`endif

    rr_pick #(.N(N_FU), .PTR_W(PTR_W)) u_pick (
        .req (req),
        .ptr (search_base),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Squash drains every done FU at once and takes precedence over stall.
    always_comb begin
        ack = '0;
        if (reset) begin
            ack = '0;
        end else if (squash) begin
            ack = req;
        end else if (!cdb_stall) begin
            ack = pick_gnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_packet <= '0;
            grant_idx  <= '0;
        end else if (squash) begin
            cdb_packet <= '0;
            grant_idx  <= '0;
        end else if (!cdb_stall && pick_any) begin
            cdb_packet <= fu_to_cdb(fu_out_packet[pick_idx]);
            grant_idx  <= pick_idx;
        end else begin
            // One-cycle broadcast: never hold a stale result on the bus.
            cdb_packet <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a reference model.
// Expectations adapt to CDB_RR_EN (round-robin) or its absence (fixed priority).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;
`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         squash;
    logic         cdb_stall;
    FU_OUT_PACKET fu_out_packet [N];
    logic [N-1:0] ack;
    CDB_PACKET    cdb_packet;
    logic [1:0]   grant_idx;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.N_FU(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .cdb_stall     (cdb_stall),
        .fu_out_packet (fu_out_packet),
        .ack           (ack),
        .cdb_packet    (cdb_packet),
        .grant_idx     (grant_idx)
    );

    // ---------------- drivers ----------------
    task automatic drive(input logic [N-1:0] r, input logic st, input logic sq);
        for (int i = 0; i < N; i++) begin
            fu_out_packet[i].done         = r[i];
            fu_out_packet[i].rob_tag      = ROB_TAG_W'($urandom);
            fu_out_packet[i].v            = $urandom;
            fu_out_packet[i].take_branch  = 1'($urandom);
            fu_out_packet[i].branch_loc   = $urandom;
            fu_out_packet[i].mispredicted = 1'($urandom);
            fu_out_packet[i].origin_PC    = $urandom;
        end
        cdb_stall = st;
        squash    = sq;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Winner = first requester scanning upward from the pointer, wrapping around.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic CDB_PACKET model_pkt(input int w);
        CDB_PACKET c;
        c.valid        = 1'b1;
        c.rob_tag      = fu_out_packet[w].rob_tag;
        c.v            = fu_out_packet[w].v;
        c.take_branch  = fu_out_packet[w].take_branch;
        c.branch_loc   = fu_out_packet[w].branch_loc;
        c.mispredicted = fu_out_packet[w].mispredicted;
        c.origin_PC    = fu_out_packet[w].origin_PC;
        return c;
    endfunction

    function automatic void model_advance(input int w);
        if (RR && w >= 0) m_ptr = (w + 1) % N;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL reset_ack got=%b want=0000", ack);
        end
        tick();
        checks++;
        if (cdb_packet !== '0 || grant_idx !== 2'd0) begin
            errors++; $display("FAIL reset_regs valid=%b idx=%0d want cleared", cdb_packet.valid, grant_idx);
        end
        reset = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 1'b0, 1'b0);
            #1;
            checks++;
            if (ack !== 4'b0000) begin
                errors++; $display("FAIL idle_ack c=%0d got=%b want=0000", c, ack);
            end
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b0 || grant_idx !== 2'd0) begin
                errors++; $display("FAIL idle_regs c=%0d valid=%b idx=%0d want 0/0", c, cdb_packet.valid, grant_idx);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp;
        logic [ROB_TAG_W-1:0] tag;
        for (int c = 0; c < 5; c++) begin
            exp = RR ? (c % N) : 0;
            drive(4'b1111, 1'b0, 1'b0);
            #1;
            checks++;
            if (ack !== 4'(1 << exp)) begin
                errors++; $display("FAIL rr_ack c=%0d got=%b want=%b", c, ack, 4'(1 << exp));
            end
            tag = fu_out_packet[exp].rob_tag;
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'(exp) || cdb_packet.rob_tag !== tag) begin
                errors++; $display("FAIL rr_cdb c=%0d valid=%b idx=%0d tag=%0d want 1/%0d/%0d",
                                   c, cdb_packet.valid, grant_idx, cdb_packet.rob_tag, exp, tag);
            end
            model_advance(exp);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] reqs [3];
        int           exps [3];
        reqs[0] = 4'b0100; exps[0] = 2;
        reqs[1] = 4'b1001; exps[1] = RR ? 3 : 0;
        reqs[2] = 4'b1001; exps[2] = 0;
        for (int c = 0; c < 3; c++) begin
            drive(reqs[c], 1'b0, 1'b0);
            #1;
            checks++;
            if (ack !== 4'(1 << exps[c])) begin
                errors++; $display("FAIL wrap_ack c=%0d got=%b want=%b", c, ack, 4'(1 << exps[c]));
            end
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'(exps[c])) begin
                errors++; $display("FAIL wrap_idx c=%0d valid=%b idx=%0d want 1/%0d", c, cdb_packet.valid, grant_idx, exps[c]);
            end
            model_advance(exps[c]);
        end
    endtask

    task automatic test_stall();
        int exp;
        for (int c = 0; c < 2; c++) begin
            drive(4'b0110, 1'b1, 1'b0);
            #1;
            checks++;
            if (ack !== 4'b0000) begin
                errors++; $display("FAIL stall_ack c=%0d got=%b want=0000", c, ack);
            end
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b0) begin
                errors++; $display("FAIL stall_valid c=%0d got=%b want=0", c, cdb_packet.valid);
            end
        end
        for (int c = 0; c < 2; c++) begin
            exp = (RR && c == 1) ? 2 : 1;
            drive(4'b0110, 1'b0, 1'b0);
            #1;
            checks++;
            if (ack !== 4'(1 << exp)) begin
                errors++; $display("FAIL unstall_ack c=%0d got=%b want=%b", c, ack, 4'(1 << exp));
            end
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'(exp)) begin
                errors++; $display("FAIL unstall_idx c=%0d valid=%b idx=%0d want 1/%0d", c, cdb_packet.valid, grant_idx, exp);
            end
            model_advance(exp);
        end
    endtask

    task automatic test_squash();
        int exp;
        drive(4'b1011, 1'b1, 1'b1);
        #1;
        checks++;
        if (ack !== 4'b1011) begin
            errors++; $display("FAIL squash_ack got=%b want=1011", ack);
        end
        tick();
        checks++;
        if (cdb_packet !== '0 || grant_idx !== 2'd0) begin
            errors++; $display("FAIL squash_regs valid=%b idx=%0d want cleared", cdb_packet.valid, grant_idx);
        end
        // Pointer must be untouched by the squash (3 in round-robin mode).
        exp = RR ? 3 : 0;
        drive(4'b1111, 1'b0, 1'b0);
        tick();
        checks++;
        if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'(exp)) begin
            errors++; $display("FAIL squash_ptr valid=%b idx=%0d want 1/%0d", cdb_packet.valid, grant_idx, exp);
        end
        model_advance(exp);
    endtask

    task automatic test_async_reset();
        drive(4'b0010, 1'b0, 1'b0);
        tick();
        checks++;
        if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'd1) begin
            errors++; $display("FAIL areset_pre valid=%b idx=%0d want 1/1", cdb_packet.valid, grant_idx);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cdb_packet !== '0 || grant_idx !== 2'd0 || ack !== 4'b0000) begin
            errors++; $display("FAIL areset_clear valid=%b idx=%0d ack=%b want cleared", cdb_packet.valid, grant_idx, ack);
        end
        tick();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_fixed_priority();
        int exp;
        for (int c = 0; c < 3; c++) begin
            exp = RR ? c : 0;
            drive(4'b1111, 1'b0, 1'b0);
            tick();
            checks++;
            if (cdb_packet.valid !== 1'b1 || grant_idx !== 2'(exp)) begin
                errors++; $display("FAIL prio_idx c=%0d valid=%b idx=%0d want 1/%0d", c, cdb_packet.valid, grant_idx, exp);
            end
            model_advance(exp);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         st, sq;
        int           w;
        logic [N-1:0] exp_ack;
        CDB_PACKET    exp_pkt;
        for (int c = 0; c < 300; c++) begin
            r  = N'($urandom);
            st = ($urandom_range(0, 4) == 0);
            sq = ($urandom_range(0, 9) == 0);
            drive(r, st, sq);
            w = model_pick(r);
            if (sq)                exp_ack = r;
            else if (st || w < 0)  exp_ack = '0;
            else                   exp_ack = 4'(1 << w);
            exp_pkt = (!sq && !st && w >= 0) ? model_pkt(w) : '0;
            #1;
            checks++;
            if (ack !== exp_ack) begin
                errors++; $display("FAIL rand_ack c=%0d req=%b st=%b sq=%b got=%b want=%b", c, r, st, sq, ack, exp_ack);
            end
            tick();
            checks++;
            if (cdb_packet.valid !== exp_pkt.valid) begin
                errors++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, cdb_packet.valid, exp_pkt.valid);
            end else if (exp_pkt.valid && (cdb_packet !== exp_pkt || grant_idx !== 2'(w))) begin
                errors++; $display("FAIL rand_pkt c=%0d idx=%0d tag=%0d want idx=%0d tag=%0d",
                                   c, grant_idx, cdb_packet.rob_tag, w, exp_pkt.rob_tag);
            end else if (sq && (cdb_packet !== '0 || grant_idx !== 2'd0)) begin
                errors++; $display("FAIL rand_squash c=%0d idx=%0d want cleared", c, grant_idx);
            end
            if (!sq && !st) model_advance(w);
        end
    endtask

    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_stall = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_squash();
        test_async_reset();
        test_fixed_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
